// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// It registers the ALU operands, captures the result and returns it over a per-requester handshake.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [3:0]        req_op_0,
  input  logic [3:0]        req_op_1,
  input  logic [DATA_W-1:0] req_a_0,
  input  logic [DATA_W-1:0] req_a_1,
  input  logic [DATA_W-1:0] req_b_0,
  input  logic [DATA_W-1:0] req_b_1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last_grant;
  logic              r_grant;
  logic [DATA_W-1:0] r_alu_in1;
  logic [DATA_W-1:0] r_alu_in2;
  logic [3:0]        r_alu_op;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_zero;
  logic              r_rsp_err;

  logic              w_sel;
  logic              w_fire;
  logic              w_legal;
  logic              w_shift;
  logic [3:0]        w_op;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;

  // On contention the requester that did not win last time is chosen.
  always_comb begin
    w_sel = 1'b0;
    if (req_valid == 2'b10)
      w_sel = 1'b1;
    else if (req_valid == 2'b11)
      w_sel = ~r_last_grant;
  end

  assign w_op    = w_sel ? req_op_1 : req_op_0;
  assign w_a     = w_sel ? req_a_1  : req_a_0;
  assign w_b     = w_sel ? req_b_1  : req_b_0;
  assign w_legal = ~w_op[3];
  assign w_shift = (w_op == 4'b0000) || (w_op == 4'b0011) || (w_op == 4'b0100);
  assign w_fire  = (r_state == IDLE) && (req_valid != 2'b00) && !rst;

  always_comb begin
    req_ready = '0;
    if (w_fire)
      req_ready[w_sel] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (r_state == RESP)
      rsp_valid[r_grant] = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_fire) w_next = w_legal ? EXEC : RESP;
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready[r_grant]) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_fire) begin
        r_last_grant <= w_sel;
        r_grant      <= w_sel;
      end
    end
  end

  // Illegal opcodes leave the ALU operand registers untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_in1 <= '0;
      r_alu_in2 <= '0;
      r_alu_op  <= 4'b0010;
    end else if (w_fire && w_legal) begin
      r_alu_in1 <= w_a;
      r_alu_op  <= w_op;
      if (w_shift)
        r_alu_in2 <= {{(DATA_W-5){1'b0}}, w_b[4:0]};
      else
        r_alu_in2 <= w_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else if (r_state == EXEC) begin
      r_rsp_data <= alu_out;
      r_rsp_zero <= alu_z;
      r_rsp_err  <= 1'b0;
    end else if (w_fire && !w_legal) begin
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
      r_rsp_err  <= 1'b1;
    end
  end

  assign alu_in1  = r_alu_in1;
  assign alu_in2  = r_alu_in2;
  assign alu_op   = r_alu_op;
  assign rsp_data = r_rsp_data;
  assign rsp_zero = r_rsp_zero;
  assign rsp_err  = r_rsp_err;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: drives a reference ALU, queues expected
// responses at each accepted request and compares them as responses appear.
module tb_alu_arbiter;

  localparam int unsigned DW = 32;

  typedef struct {
    logic [1:0]    vld;
    logic [DW-1:0] data;
    logic          zero;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [3:0]    req_op_0, req_op_1;
  logic [DW-1:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero, rsp_err;
  logic [DW-1:0] alu_in1, alu_in2;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_out;
  logic          alu_z;
  logic          busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   grants[$];

  alu_arbiter #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1),
    .req_b_0(req_b_0), .req_b_1(req_b_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
    case (op)
      4'b0010: alu_fn = x + y;
      4'b0110: alu_fn = x - y;
      4'b0000: alu_fn = x << y[4:0];
      4'b0011: alu_fn = x >> y[4:0];
      4'b0100: alu_fn = $unsigned($signed(x) >>> y[4:0]);
      4'b0001: alu_fn = x | y;
      4'b0101: alu_fn = x & y;
      4'b0111: alu_fn = x ^ y;
      default: alu_fn = '0;
    endcase
  endfunction

  always_comb begin
    alu_out = alu_fn(alu_op, alu_in1, alu_in2);
    alu_z   = (alu_out == '0);
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    logic [DW-1:0] bm;
    e.vld = (r == 1) ? 2'b10 : 2'b01;
    if (op[3]) begin
      e.data = '0; e.zero = 1'b0; e.err = 1'b1;
    end else begin
      bm = b;
      if (op == 4'b0000 || op == 4'b0011 || op == 4'b0100) bm = {27'b0, b[4:0]};
      e.data = alu_fn(op, a, bm);
      e.zero = (e.data == '0);
      e.err  = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic cmp_front();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL unexpected_rsp observed=%b expected=none", rsp_valid);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rsp_valid", rsp_valid, e.vld);
      check("rsp_data", rsp_data, e.data);
      check("rsp_zero", rsp_zero, e.zero);
      check("rsp_err", rsp_err, e.err);
    end
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (r == 0) begin req_op_0 = op; req_a_0 = a; req_b_0 = b; end
    else        begin req_op_1 = op; req_a_1 = a; req_b_1 = b; end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input int r, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, output int hs);
    bit done = 1'b0;
    hs = -1;
    set_req(r, op, a, b);
    req_valid[r] = 1'b1;
    for (int k = 0; k < 30 && !done; k++) begin
      #1;
      if (req_ready[r]) begin
        push(r, op, a, b);
        hs = cyc + 1;
        done = 1'b1;
      end
      @(negedge clk);
    end
    req_valid[r] = 1'b0;
    check("grant_timeout", done, 1'b1);
  endtask

  task automatic recv(output int rc);
    bit got = 1'b0;
    rc = -1;
    for (int k = 0; k < 30 && !got; k++) begin
      #1;
      if (rsp_valid != 2'b00) begin
        got = 1'b1;
        rc = cyc;
        cmp_front();
      end
      @(negedge clk);
    end
    check("rsp_timeout", got, 1'b1);
  endtask

  initial begin
    int hs, rc;
    bit seen;
    logic [DW-1:0] s_in1, s_in2, held;
    logic [3:0] s_op;

    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
    set_req(0, 4'b0010, 0, 0);
    set_req(1, 4'b0010, 0, 0);
    @(negedge clk); @(negedge clk); #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_zero", rsp_zero, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_alu_in1", alu_in1, 0);
    check("rst_alu_in2", alu_in2, 0);
    check("rst_alu_op", alu_op, 4'b0010);
    check("rst_busy", busy, 1'b0);
    req_valid = 2'b00;
    @(negedge clk); rst = 1'b0;

    // Single ADD from requester 0
    send(0, 4'b0010, 5, 7, hs);
    check("add_alu_op", alu_op, 4'b0010);
    check("add_alu_in1", alu_in1, 5);
    check("add_alu_in2", alu_in2, 7);
    check("add_busy_exec", busy, 1'b1);
    recv(rc);
    check("add_latency", rc, hs + 1);
    #1;
    check("add_busy_done", busy, 1'b0);

    // Contention after a fresh reset: grants alternate starting at 0
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    set_req(0, 4'b0010, 3, 4);
    set_req(1, 4'b0110, 9, 9);
    req_valid = 2'b11; rsp_ready = 2'b11;
    grants.delete();
    for (int k = 0; k < 60 && !(grants.size() == 4 && sb.size() == 0); k++) begin
      #1;
      if (rsp_valid != 2'b00) cmp_front();
      if (grants.size() == 4) req_valid = 2'b00;
      else if (req_ready != 2'b00) begin
        check("rdy_onehot", $onehot(req_ready), 1'b1);
        grants.push_back(req_ready[1] ? 1 : 0);
        if (req_ready[1]) push(1, 4'b0110, 9, 9);
        else              push(0, 4'b0010, 3, 4);
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    check("rr_grant_count", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++)
      check($sformatf("rr_grant%0d", i), grants[i], i % 2);

    // Shifts: amount masked to 5 bits, SRA sign-extends
    send(1, 4'b0000, 1, 32'h23, hs);
    check("sll_alu_in2", alu_in2, 3);
    recv(rc);
    send(1, 4'b0100, 32'h8000_0000, 4, hs);
    check("sra_alu_in2", alu_in2, 4);
    recv(rc);

    // Illegal opcode: ALU registers held, error response next cycle
    s_in1 = alu_in1; s_in2 = alu_in2; s_op = alu_op;
    send(0, 4'b1010, 32'h55, 32'h66, hs);
    check("ill_alu_in1", alu_in1, s_in1);
    check("ill_alu_in2", alu_in2, s_in2);
    check("ill_alu_op", alu_op, s_op);
    recv(rc);
    check("ill_latency", rc, hs);

    // Response stalled with requester 1 pending; its rsp_ready must be ignored
    rsp_ready = 2'b10;
    send(0, 4'b0010, 10, 20, hs);
    set_req(1, 4'b0111, 32'hF0F0, 32'h0FF0);
    req_valid[1] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      #1;
      if (rsp_valid != 2'b00) seen = 1'b1;
      else @(negedge clk);
    end
    check("stall_rsp_seen", seen, 1'b1);
    held = rsp_data;
    check("stall_data_first", held, 30);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("stall_rsp_valid", rsp_valid, 2'b01);
      check("stall_rsp_data", rsp_data, held);
      check("stall_req_ready", req_ready, 2'b00);
    end
    rsp_ready = 2'b11;
    #1;
    cmp_front();
    @(negedge clk); #1;
    check("stall_next_grant", req_ready, 2'b10);
    push(1, 4'b0111, 32'hF0F0, 32'h0FF0);
    @(negedge clk);
    req_valid = 2'b00;
    recv(rc);

    // Reset during EXEC aborts the transaction
    send(0, 4'b0010, 1, 1, hs);
    check("abort_busy_exec", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", rsp_valid, 2'b00);
    check("abort_busy", busy, 1'b0);
    check("abort_alu_in1", alu_in1, 0);
    check("abort_alu_op", alu_op, 4'b0010);
    check("abort_rsp_data", rsp_data, 0);
    sb.delete();
    @(negedge clk); #1;
    check("abort_no_rsp", rsp_valid, 2'b00);
    rst = 1'b0;
    set_req(0, 4'b0010, 2, 3);
    set_req(1, 4'b0101, 32'hFF, 32'h0F);
    req_valid = 2'b11;
    #1;
    check("abort_first_grant", req_ready, 2'b01);
    push(0, 4'b0010, 2, 3);
    @(negedge clk);
    req_valid = 2'b00;
    recv(rc);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
